// File: rtl/uart_rx_pkg.sv
//------------------------------------------------------------------------------
// Module   : uart_rx_pkg
// Purpose  : Shared types and constants for the UART RX edge/bit counter and
//            its sample-window decoder.
// Contents : state_t (IDLE, RUN, DONE), prescale/frame limits and the
//            majority-window offsets about the bit midpoint H = P/2.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Prescale substituted when the requested one is illegal
  localparam int PRESCALE_DEFAULT = 16;
  // Smallest prescale that still holds a full 3-edge window
  localparam int PRESCALE_MIN     = 4;
  // Start + stop is the shortest meaningful frame
  localparam int FRAME_BITS_MIN   = 2;

  // Prescales accepted by the base build
  localparam int PRESCALE_LEGAL_A = 8;
  localparam int PRESCALE_LEGAL_B = 16;
  localparam int PRESCALE_LEGAL_C = 32;

  // Majority-window edges relative to the bit midpoint H
  localparam int SAMPLE_OFS_FIRST = -2;
  localparam int SAMPLE_OFS_MID   = -1;
  localparam int SAMPLE_OFS_LAST  = 0;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sample_decode.sv
//------------------------------------------------------------------------------
// Module   : uart_rx_sample_decode
// Purpose  : Combinational decode of the mid-bit majority window and the
//            end-of-bit strobe from an edge counter and a latched prescale.
//            Shared with the TX-side timing checker.
// Ports    : edge_count  in  edge index within the bit
//            prescale    in  latched prescale P (>= 4)
//            run         in  counter is actively timing a bit
//            sample_en   out edge_count in {H-2, H-1, H}
//            sample_last out edge_count == H
//            bit_done    out edge_count == P-1
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_sample_decode
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic [PRESCALE_W-1:0] edge_count,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  run,
  output logic                  sample_en,
  output logic                  sample_last,
  output logic                  bit_done
);

  // Negative offsets wrap modulo 2^PRESCALE_W; with P >= 4 the sums stay
  // in range, so the result is the true edge index.
  localparam logic [PRESCALE_W-1:0] c_ofs_first = PRESCALE_W'(SAMPLE_OFS_FIRST);
  localparam logic [PRESCALE_W-1:0] c_ofs_mid   = PRESCALE_W'(SAMPLE_OFS_MID);
  localparam logic [PRESCALE_W-1:0] c_ofs_last  = PRESCALE_W'(SAMPLE_OFS_LAST);

  logic [PRESCALE_W-1:0] w_half;
  logic [PRESCALE_W-1:0] w_first;
  logic [PRESCALE_W-1:0] w_mid;
  logic [PRESCALE_W-1:0] w_last;

  assign w_half  = prescale >> 1;
  assign w_first = w_half + c_ofs_first;
  assign w_mid   = w_half + c_ofs_mid;
  assign w_last  = w_half + c_ofs_last;

  assign sample_en   = run & ((edge_count == w_first) |
                              (edge_count == w_mid)   |
                              (edge_count == w_last));
  assign sample_last = run & (edge_count == w_last);
  assign bit_done    = run & (edge_count == (prescale - PRESCALE_W'(1)));

endmodule

`default_nettype wire

// File: rtl/uart_rx_edge_bit_counter_p.sv
//------------------------------------------------------------------------------
// Module   : uart_rx_edge_bit_counter_p
// Purpose  : Oversampling edge/bit counter for the UART RX path. Counts edges
//            within a bit and bits within a frame, and provides the sample
//            window strobes, end-of-bit and frame completion.
// Ports    : clk         in  receive oversampling clock
//            rst         in  asynchronous active-low reset
//            enable      in  frame in progress (from RX FSM)
//            prescale    in  requested edges per bit
//            frame_bits  in  bits per frame (start+data+parity+stop)
//            edge_count  out edge index within the bit
//            bit_count   out bit index within the frame
//            sample_en   out majority window active
//            sample_last out last edge of the majority window
//            bit_done    out last edge of the bit
//            frame_done  out one-cycle pulse after the final bit
//            cfg_err     out latched prescale was illegal (16 used instead)
// Config   : UART_RX_PRESCALE_ANY_EN - accept any even prescale >= 4
//            instead of only 8/16/32.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_edge_bit_counter_p
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [BIT_CNT_W-1:0]  frame_bits,
  output logic [PRESCALE_W-1:0] edge_count,
  output logic [BIT_CNT_W-1:0]  bit_count,
  output logic                  sample_en,
  output logic                  sample_last,
  output logic                  bit_done,
  output logic                  frame_done,
  output logic                  cfg_err
);

  state_t                r_state;
  logic [PRESCALE_W-1:0] r_p;
  logic [BIT_CNT_W-1:0]  r_f;

  logic                  w_legal;
  logic [PRESCALE_W-1:0] w_p_eff;
  logic [BIT_CNT_W-1:0]  w_f_eff;
  logic                  w_run;
  logic                  w_bit_last;

`ifdef UART_RX_PRESCALE_ANY_EN
  // Any even value from the minimum up; the top even code 2^W-2 is the
  // largest even value the port can carry, so no upper check is needed.
  assign w_legal = ~prescale[0] && (int'(prescale) >= PRESCALE_MIN);
`else
  assign w_legal = (int'(prescale) == PRESCALE_LEGAL_A) ||
                   (int'(prescale) == PRESCALE_LEGAL_B) ||
                   (int'(prescale) == PRESCALE_LEGAL_C);
`endif

  assign w_p_eff = w_legal ? prescale : PRESCALE_W'(PRESCALE_DEFAULT);
  assign w_f_eff = (int'(frame_bits) < FRAME_BITS_MIN) ?
                   BIT_CNT_W'(FRAME_BITS_MIN) : frame_bits;

  assign w_run      = (r_state == RUN);
  assign w_bit_last = (bit_count == (r_f - BIT_CNT_W'(1)));

  // Strobes decode the registered counters against the latched prescale,
  // so they are glitch-free relative to clk and low outside RUN.
  uart_rx_sample_decode #(
    .PRESCALE_W (PRESCALE_W)
  ) u_decode (
    .edge_count  (edge_count),
    .prescale    (r_p),
    .run         (w_run),
    .sample_en   (sample_en),
    .sample_last (sample_last),
    .bit_done    (bit_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_p        <= PRESCALE_W'(PRESCALE_DEFAULT);
      r_f        <= BIT_CNT_W'(FRAME_BITS_MIN);
      edge_count <= '0;
      bit_count  <= '0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          edge_count <= '0;
          bit_count  <= '0;
          if (enable) begin
            // Configuration is sampled only here; later input changes
            // cannot disturb a frame in flight.
            r_p     <= w_p_eff;
            r_f     <= w_f_eff;
            cfg_err <= ~w_legal;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (!enable) begin
            edge_count <= '0;
            bit_count  <= '0;
            r_state    <= IDLE;
          end else if (bit_done) begin
            edge_count <= '0;
            if (w_bit_last) begin
              bit_count  <= '0;
              frame_done <= 1'b1;
              r_state    <= DONE;
            end else begin
              bit_count <= bit_count + BIT_CNT_W'(1);
            end
          end else begin
            edge_count <= edge_count + PRESCALE_W'(1);
          end
        end
        DONE: begin
          edge_count <= '0;
          bit_count  <= '0;
          if (!enable) begin
            r_state <= IDLE;
          end
        end
        default: begin
          edge_count <= '0;
          bit_count  <= '0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
